chunk_adder: RTL and testbench
==============================

CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter CHUNK, default 4: bits processed per cycle; WIDTH % CHUNK == 0 SHALL hold; N = WIDTH/CHUNK.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a new operation; honoured only while ready=1.
REQ-006 op  input  2  operation: 00 ADD, 01 SUB, 10 SADD (unsigned saturating add), 11 ACC (res + a).
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; ignored for ACC.
REQ-009 ready  output  1  block idle, start will be accepted.
REQ-010 busy  output  1  operation in progress.
REQ-011 done  output  1  one-cycle pulse; res/cout/ovf updated this cycle.
REQ-012 res  output  WIDTH  registered result; holds until next done.
REQ-013 cout  output  1  carry out of MSB (SUB: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the unsaturated result.

Function
REQ-015 FSM states IDLE, CALC, DONE; ready=1 only in IDLE, busy=1 only in CALC.
REQ-016 IDLE with start=1: latch a, b (or res for ACC as second operand), op; set chunk index 0; carry_in=1 for SUB else 0; go CALC; ready<=0, busy<=1.
REQ-017 SUB SHALL use bitwise-inverted B with carry_in=1; ACC SHALL compute latched res + latched a.
REQ-018 CALC: each cycle adds one CHUNK slice (LSB slice first) plus carry; carry registered between slices; after slice N-1 go DONE.
REQ-019 DONE: write res, cout, ovf; done<=1 for exactly one cycle; busy<=0, ready<=1; next state IDLE.
REQ-020 Latency: start sampled at edge k -> done, res valid after edge k+N+1; throughput one op per N+1 cycles.
REQ-021 start asserted in the cycle done=1 SHALL be accepted (back-to-back operation).
REQ-022 start while busy SHALL be ignored; operand/op changes while busy SHALL not affect the result.
REQ-023 SADD with cout=1 SHALL write res = all ones; other ops wrap modulo 2^WIDTH.
REQ-024 ovf: ADD/SADD/ACC = operands same MSB and sum MSB differs; SUB = operand MSBs differ and result MSB differs from A MSB.
REQ-025 op values are all legal; no undefined encodings.

Reset
REQ-026 rst=1: state IDLE, ready=1, busy=0, done=0, res=0, cout=0, ovf=0, chunk index 0, carry 0.
REQ-027 rst during CALC or DONE SHALL abort: no done pulse, res returns to 0, ready=1 on the cycle after rst.
REQ-028 rst has priority over start in the same cycle.

Structure
REQ-029 Shared package arith_pkg SHALL hold op encodings (OP_ADD, OP_SUB, OP_SADD, OP_ACC) and the FSM state type.
REQ-030 One sub-module chunk_add: CHUNK-bit combinational adder with carry in/out, instantiated once.
REQ-031 Parameter legality (WIDTH % CHUNK) SHALL be checked at elaboration.

Verification (WIDTH=16, CHUNK=4, N=4)
REQ-032 Reset -> ready=1, busy=0, done=0, res=0x0000, cout=0, ovf=0.
REQ-033 ADD 0x1234+0x0FFF, start at edge k -> done after edge k+5, res=0x2233, cout=0, ovf=0; busy high for 4 cycles.
REQ-034 SUB 0x0001-0x0002 -> res=0xFFFF, cout=0, ovf=0; ADD 0x7FFF+0x0001 -> res=0x8000, ovf=1.
REQ-035 SADD 0xFFF0+0x0020 -> res=0xFFFF, cout=1; ADD same operands -> res=0x0010, cout=1.
REQ-036 From reset, ACC a=5 three times, each start in the done cycle -> res 0x0005, 0x000A, 0x000F, done every 5 cycles; extra start while busy ignored.
REQ-037 rst asserted 2 cycles into CALC -> no done pulse, res=0x0000, ready=1 next cycle; following ADD 1+1 -> res=0x0002.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the chunked arithmetic block: op encodings and FSM state.
package arith_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_SADD = 2'b10,
      OP_ACC  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/chunk_add.sv
// CHUNK-bit combinational adder slice with carry in and carry out.
module chunk_add #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/chunk_adder.sv
// Multi-cycle adder: processes one CHUNK slice per cycle, LSB first, through a
// single shared chunk_add. Supports add, subtract, saturating add and accumulate.
module chunk_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             ovf
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   generate
      if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("chunk_adder: WIDTH must be a positive multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   op_t              op_r;
   logic [WIDTH-1:0] opa, opb, sum_r;
   logic             a_msb, b_msb;
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [CHUNK-1:0]       s_slice;
   logic                   c_slice;
   logic [WIDTH-1:0]       b_eff;
   logic [WIDTH+CHUNK-1:0] sum_shift;

   // Second operand as the adder sees it: ACC folds the current result back in.
   always_comb begin
      b_eff = b;
      if (op_t'(op) == OP_SUB)      b_eff = ~b;
      else if (op_t'(op) == OP_ACC) b_eff = res;
   end

   assign sum_shift = {s_slice, sum_r};

   chunk_add #(.CHUNK(CHUNK)) u_add (
      .x  (opa[CHUNK-1:0]),
      .y  (opb[CHUNK-1:0]),
      .ci (carry),
      .s  (s_slice),
      .co (c_slice)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op_r  <= OP_ADD;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         res   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         sum_r <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         carry <= 1'b0;
         idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  opa   <= a;
                  opb   <= b_eff;
                  a_msb <= a[WIDTH-1];
                  b_msb <= b_eff[WIDTH-1];
                  op_r  <= op_t'(op);
                  idx   <= '0;
                  carry <= (op_t'(op) == OP_SUB);
                  state <= CALC;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            CALC: begin
               // Operands shift down so the active slice is always at bit 0.
               opa   <= opa >> CHUNK;
               opb   <= opb >> CHUNK;
               sum_r <= sum_shift[WIDTH+CHUNK-1:CHUNK];
               carry <= c_slice;
               idx   <= idx + 1'b1;
               if (idx == IDXW'(N - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               res   <= (op_r == OP_SADD && carry) ? '1 : sum_r;
               cout  <= carry;
               ovf   <= (a_msb == b_msb) && (sum_r[WIDTH-1] != a_msb);
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_adder.sv
// Self-checking bench for chunk_adder (WIDTH=16, CHUNK=4): scoreboard of
// expected results checked on every done pulse, plus per-scenario timing checks.
module tb_chunk_adder;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        ready, busy, done, cout, ovf;
   logic [15:0] res;

   typedef struct {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mres;
   int          compared = 0;
   int          mismatched = 0;

   always #5 clk = ~clk;

   chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .res(res), .cout(cout), .ovf(ovf)
   );

   function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, y, r);
      exp_t        e;
      logic [16:0] u;
      int          sx, sy, sr, s;
      sx = int'($signed(x));
      sy = int'($signed(y));
      sr = int'($signed(r));
      case (o)
         2'b01: begin
            u = {(x >= y), 16'(x - y)};
            s = sx - sy;
         end
         2'b11: begin
            u = {1'b0, x} + {1'b0, r};
            s = sx + sr;
         end
         default: begin
            u = {1'b0, x} + {1'b0, y};
            s = sx + sy;
         end
      endcase
      e.res  = (o == 2'b10 && u[16]) ? 16'hFFFF : u[15:0];
      e.cout = u[16];
      e.ovf  = (s > 32767) || (s < -32768);
      return e;
   endfunction

   // Scoreboard: every done pulse pops and checks the oldest expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         compared++;
         if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_done: got done=1 with res=%h, expected no pulse", res);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (res !== e.res || cout !== e.cout || ovf !== e.ovf) begin
               mismatched++;
               $display("FAIL result: got res=%h cout=%b ovf=%b, expected res=%h cout=%b ovf=%b",
                        res, cout, ovf, e.res, e.cout, e.ovf);
            end
         end
      end
   end

   // Called at posedge+1; drives start for exactly one edge and records expectation.
   task automatic issue(input logic [1:0] o, input logic [15:0] x, y);
      exp_t e;
      e = model(o, x, y, mres);
      mres = e.res;
      sb.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts edges until done is seen; lat includes n0 edges already elapsed.
   task automatic wait_done(input int n0, output int lat, output int bc);
      lat = n0;
      bc  = 0;
      while (1) begin
         if (busy) bc++;
         @(posedge clk); #1;
         lat++;
         if (done) break;
         if (lat > 20) begin
            compared++; mismatched++;
            $display("FAIL done_timeout: got no done after %0d edges, expected within 20", lat);
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      mres = '0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if ({ready, busy, done, res, cout, ovf} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         mismatched++;
         $display("FAIL reset_state: got rdy=%b busy=%b done=%b res=%h cout=%b ovf=%b, expected 1 0 0 0000 0 0",
                  ready, busy, done, res, cout, ovf);
      end
   endtask

   task automatic test_add_latency();
      int lat, bc;
      issue(2'b00, 16'h1234, 16'h0FFF);
      wait_done(0, lat, bc);
      compared++;
      if (lat !== 5) begin
         mismatched++;
         $display("FAIL add_latency: got %0d edges, expected 5", lat);
      end
      compared++;
      if (bc !== 4) begin
         mismatched++;
         $display("FAIL add_busy_cycles: got %0d, expected 4", bc);
      end
      compared++;
      if (ready !== 1'b1 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL done_cycle_flags: got rdy=%b busy=%b, expected 1 0", ready, busy);
      end
   endtask

   task automatic test_sub_ovf();
      int lat, bc;
      issue(2'b01, 16'h0001, 16'h0002);
      wait_done(0, lat, bc);
      @(posedge clk); #1;
      issue(2'b00, 16'h7FFF, 16'h0001);
      wait_done(0, lat, bc);
      @(posedge clk); #1;
   endtask

   task automatic test_sadd();
      int lat, bc;
      issue(2'b10, 16'hFFF0, 16'h0020);
      wait_done(0, lat, bc);
      @(posedge clk); #1;
      issue(2'b00, 16'hFFF0, 16'h0020);
      wait_done(0, lat, bc);
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back_acc();
      int lat, bc;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue(2'b11, 16'h0005, 16'hAAAA);
         if (i == 1) begin
            // Stray start and operand churn while busy must have no effect.
            start = 1'b1; op = 2'b00; a = 16'hFFFF; b = 16'hFFFF;
            @(posedge clk); #1;
            start = 1'b0; a = 16'h1111;
            wait_done(1, lat, bc);
         end else begin
            wait_done(0, lat, bc);
         end
         compared++;
         if (lat !== 5) begin
            mismatched++;
            $display("FAIL acc_latency[%0d]: got %0d edges, expected 5", i, lat);
         end
      end
      compared++;
      if (res !== 16'h000F) begin
         mismatched++;
         $display("FAIL acc_final: got %h, expected 000f", res);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int lat, bc, pulses;
      issue(2'b00, 16'h4321, 16'h1111);
      @(posedge clk); #1;
      rst = 1'b1;
      void'(sb.pop_back());
      mres = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      compared++;
      if (ready !== 1'b1 || busy !== 1'b0 || res !== 16'h0000) begin
         mismatched++;
         $display("FAIL abort_state: got rdy=%b busy=%b res=%h, expected 1 0 0000", ready, busy, res);
      end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      compared++;
      if (pulses !== 0) begin
         mismatched++;
         $display("FAIL abort_no_done: got %0d pulses, expected 0", pulses);
      end
      issue(2'b00, 16'h0001, 16'h0001);
      wait_done(0, lat, bc);
      compared++;
      if (res !== 16'h0002) begin
         mismatched++;
         $display("FAIL post_abort_add: got %h, expected 0002", res);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat, bc;
      for (int i = 0; i < 12; i++) begin
         issue(2'($urandom_range(3)), 16'($urandom), 16'($urandom));
         wait_done(0, lat, bc);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; mres = '0;
      @(posedge clk); #1;
      test_reset();
      test_add_latency();
      test_sub_ovf();
      test_sadd();
      test_back_to_back_acc();
      test_abort();
      test_random();
      compared++;
      if (sb.size() !== 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
